// File: rtl/alu_seq_multiplier_if.sv
// Start/busy/done handshake and operand/product bus between the control unit and the
// sequential multiplier.
interface alu_seq_multiplier_if #(
  parameter int BUS_SIZE = 16
) ();
  logic                start;
  logic [BUS_SIZE-1:0] op_a;
  logic [BUS_SIZE-1:0] op_b;
  logic                busy;
  logic                done;
  logic [BUS_SIZE-1:0] product_hi;
  logic [BUS_SIZE-1:0] product_lo;
  logic                zero;
  logic                hi_nonzero;

  modport master (
    output start, op_a, op_b,
    input  busy, done, product_hi, product_lo, zero, hi_nonzero
  );

  modport slave (
    input  start, op_a, op_b,
    output busy, done, product_hi, product_lo, zero, hi_nonzero
  );
endinterface

// File: rtl/alu_seq_multiplier.sv
// Unsigned shift-and-add multiplier: one bit of the multiplier per cycle, sharing a single
// ripple Adder for every partial sum; the product is registered when DONE is entered.
module alu_seq_multiplier #(
  parameter int BUS_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  alu_seq_multiplier_if.slave   bus
);
  localparam int CNT_W = $clog2(BUS_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUS_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [BUS_SIZE-1:0] mcand_q, mcand_d;
  logic [BUS_SIZE-1:0] acc_q, acc_d;
  logic [BUS_SIZE-1:0] mplr_q, mplr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BUS_SIZE-1:0] prod_hi_q, prod_hi_d;
  logic [BUS_SIZE-1:0] prod_lo_q, prod_lo_d;
  logic                zero_q, zero_d;
  logic                hi_nz_q, hi_nz_d;

  logic [BUS_SIZE-1:0] add_sum;
  logic                add_c;
  logic [BUS_SIZE-1:0] shift_hi;
  logic [BUS_SIZE-1:0] shift_lo;

  Adder #(.WIDTH(BUS_SIZE)) u_adder (
    .a        (acc_q),
    .b        (mcand_q),
    .c_in     (1'b0),
    .sum      (add_sum),
    .overflow (add_c)
  );

  // Adder carry-out becomes the top bit of the shifted {acc,mplr}, so nothing wraps.
  assign shift_hi = mplr_q[0] ? {add_c, add_sum[BUS_SIZE-1:1]} : {1'b0, acc_q[BUS_SIZE-1:1]};
  assign shift_lo = {(mplr_q[0] ? add_sum[0] : acc_q[0]), mplr_q[BUS_SIZE-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    zero_d    = zero_q;
    hi_nz_d   = hi_nz_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_d = bus.op_a;
          mplr_d  = bus.op_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d  = shift_hi;
        mplr_d = shift_lo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          prod_hi_d = shift_hi;
          prod_lo_d = shift_lo;
          zero_d    = ~|{shift_hi, shift_lo};
          hi_nz_d   = |shift_hi;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      zero_q    <= 1'b1;
      hi_nz_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      zero_q    <= zero_d;
      hi_nz_q   <= hi_nz_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.product_hi = prod_hi_q;
  assign bus.product_lo = prod_lo_q;
  assign bus.zero       = zero_q;
  assign bus.hi_nonzero = hi_nz_q;
endmodule

// Ripple-carry adder; overflow is the carry out of the top bit.
module Adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);
  always_comb begin
    logic c;
    sum = '0;
    c   = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    overflow = c;
  end
endmodule

// File: tb/tb_alu_seq_multiplier.sv
// Directed bench for alu_seq_multiplier: handshake timing, products, flags, reset abort,
// ignored start during RUN and back-to-back operation.
module tb_alu_seq_multiplier;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  alu_seq_multiplier_if #(.BUS_SIZE(16)) mif ();

  alu_seq_multiplier #(.BUS_SIZE(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the accepting edge; returns sampled just after it.
  task automatic kick(input logic [15:0] a, input logic [15:0] b);
    mif.op_a  = a;
    mif.op_b  = b;
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!mif.done && n < max) begin
      step();
      n++;
      if (mif.busy && mif.done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%b done=%b expected not both high", mif.busy, mif.done);
      end
    end
    checks++;
    if (!mif.done) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", max);
    end
  endtask

  task automatic check_prod(input string name, input logic [15:0] hi, input logic [15:0] lo,
                            input logic z, input logic hnz);
    checks++;
    if ({mif.product_hi, mif.product_lo, mif.zero, mif.hi_nonzero} !== {hi, lo, z, hnz}) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h zero=%b hnz=%b expected hi=%h lo=%h zero=%b hnz=%b",
               name, mif.product_hi, mif.product_lo, mif.zero, mif.hi_nonzero, hi, lo, z, hnz);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    mif.start = 1'b1;
    mif.op_a  = 16'h0003;
    mif.op_b  = 16'h0003;
    step();
    step();
    checks++;
    if ({mif.busy, mif.done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b expected 0 0", mif.busy, mif.done);
    end
    check_prod("reset_prod", 16'h0000, 16'h0000, 1'b1, 1'b0);
    mif.start = 1'b0;
    reset_n   = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int nbusy = 0;
    int dcyc  = 0;
    mif.op_a  = 16'd3;
    mif.op_b  = 16'd5;
    mif.start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      mif.start = 1'b0;
      if (mif.busy) nbusy++;
      if (mif.done) begin
        dcyc = k;
        break;
      end
    end
    checks++;
    if (nbusy != 16) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d expected 16", nbusy);
    end
    checks++;
    if (dcyc != 17) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d expected 17", dcyc);
    end
    check_prod("basic_3x5", 16'h0000, 16'h000F, 1'b0, 1'b0);
    step();
    checks++;
    if ({mif.busy, mif.done} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done_pulse: busy=%b done=%b expected 0 0", mif.busy, mif.done);
    end
    check_prod("basic_hold", 16'h0000, 16'h000F, 1'b0, 1'b0);
  endtask

  task automatic test_max();
    int n;
    kick(16'hFFFF, 16'hFFFF);
    wait_done(40, n);
    check_prod("max_ffff", 16'hFFFE, 16'h0001, 1'b0, 1'b1);
    step();
  endtask

  task automatic test_zero();
    int n;
    kick(16'h1234, 16'h0000);
    for (int k = 0; k < 5; k++) step();
    check_prod("zero_hold_during_run", 16'hFFFE, 16'h0001, 1'b0, 1'b1);
    wait_done(40, n);
    check_prod("zero_product", 16'h0000, 16'h0000, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_ignore_start();
    int n;
    kick(16'd7, 16'd9);
    for (int k = 0; k < 4; k++) step();
    mif.op_a  = 16'hFFFF;
    mif.op_b  = 16'hFFFF;
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    wait_done(40, n);
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL ignore_done_time: got %0d cycles after pulse expected 11", n);
    end
    check_prod("ignore_7x9", 16'h0000, 16'h003F, 1'b0, 1'b0);
    step();
    checks++;
    if ({mif.busy, mif.done} !== 2'b00) begin
      errors++;
      $display("FAIL ignore_single_done: busy=%b done=%b expected 0 0", mif.busy, mif.done);
    end
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic seen = 1'b0;
    kick(16'h1111, 16'h0003);
    for (int k = 0; k < 7; k++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if ({mif.busy, mif.done} !== 2'b00) begin
      errors++;
      $display("FAIL midrun_reset_ctrl: busy=%b done=%b expected 0 0", mif.busy, mif.done);
    end
    check_prod("midrun_reset_prod", 16'h0000, 16'h0000, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step();
      if (mif.done || mif.busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrun_no_done: activity after reset got 1 expected 0");
    end
    kick(16'd6, 16'd7);
    wait_done(40, n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL midrun_restart_latency: got %0d expected 16", n);
    end
    check_prod("midrun_restart_6x7", 16'h0000, 16'h002A, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    kick(16'h0100, 16'h0100);
    wait_done(40, n);
    check_prod("b2b_first", 16'h0001, 16'h0000, 1'b0, 1'b1);
    mif.op_a  = 16'h00FF;
    mif.op_b  = 16'h0002;
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    checks++;
    if ({mif.busy, mif.done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_busy_rise: busy=%b done=%b expected 1 0", mif.busy, mif.done);
    end
    check_prod("b2b_hold", 16'h0001, 16'h0000, 1'b0, 1'b1);
    wait_done(40, n);
    checks++;
    if (n + 1 != 17) begin
      errors++;
      $display("FAIL b2b_second_done: got %0d cycles expected 17", n + 1);
    end
    check_prod("b2b_second", 16'h0000, 16'h01FE, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    reset_n   = 1'b0;
    mif.start = 1'b0;
    mif.op_a  = '0;
    mif.op_b  = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
